// File: rtl/coreabc_ram_pkg.sv
// Shared state encoding and elaboration-time helpers for the parametrised
// controller RAM.
package coreabc_ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin end
    return r;
  endfunction

  // Byte-lane storage needs whole bytes, and every word must be addressable.
  function automatic bit param_ok(input int dw, input int aw, input int depth);
    return (dw > 0) && (dw % 8 == 0) && (depth >= 1) && (clog2(depth) <= aw);
  endfunction

endpackage

// File: rtl/coreabc_ram_param_if.sv
// Access bus between the controller core and its program/data store.
interface coreabc_ram_param_if
  import coreabc_ram_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 8
);
  logic                  WEN;
  logic                  REN;
  logic [AWIDTH-1:0]     WADDR;
  logic [AWIDTH-1:0]     RADDR;
  logic [DWIDTH-1:0]     WD;
  logic [DWIDTH/8-1:0]   WBE;
  logic [DWIDTH-1:0]     RD;
  logic                  RVALID;
  logic                  BUSY;

  modport master (output WEN, REN, WADDR, RADDR, WD, WBE,
                  input  RD, RVALID, BUSY);
  modport slave  (input  WEN, REN, WADDR, RADDR, WD, WBE,
                  output RD, RVALID, BUSY);
endinterface

// File: rtl/coreabc_ram_param_array.sv
// Byte-lane-enabled storage with one write and one registered read port;
// same-address read-during-write follows RDW_MODE.
module coreabc_ram_param_array
  import coreabc_ram_pkg::*;
#(
  parameter int DWIDTH   = 16,
  parameter int AWIDTH   = 8,
  parameter int DEPTH    = 256,
  parameter int RDW_MODE = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [AWIDTH-1:0]   waddr,
  input  logic [DWIDTH/8-1:0] wbe,
  input  logic [DWIDTH-1:0]   wd,
  input  logic                re,
  input  logic                rclr,
  input  logic [AWIDTH-1:0]   raddr,
  output logic [DWIDTH-1:0]   rd
);
  localparam int NBE = DWIDTH / 8;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [DWIDTH-1:0] rdata;

  always_ff @(posedge clk) begin
    if (we)
      for (int i = 0; i < NBE; i++)
        if (wbe[i]) mem[waddr][8*i +: 8] <= wd[8*i +: 8];
  end

  // Write-first: overlay the enabled lanes of the incoming word on the read.
  always_comb begin
    rdata = mem[raddr];
    if (RDW_MODE != 0 && we && waddr == raddr)
      for (int i = 0; i < NBE; i++)
        if (wbe[i]) rdata[8*i +: 8] = wd[8*i +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rd <= '0;
    else if (re) rd <= rclr ? '0 : rdata;
  end
endmodule

// File: rtl/coreabc_ram_param.sv
// Parametrised controller RAM: post-reset clear sequencer, address range
// check, optional output register and read-valid pipeline around the array.
module coreabc_ram_param
  import coreabc_ram_pkg::*;
#(
  parameter int DWIDTH         = 16,
  parameter int AWIDTH         = 8,
  parameter int DEPTH          = 256,
  parameter int RDW_MODE       = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic               RWCLK,
  input  logic               RESETN,
  coreabc_ram_param_if.slave bus
);
  localparam int               NBE    = DWIDTH / 8;
  localparam int               STAGES = (OUT_REG != 0) ? 1 : 0;
  localparam logic [AWIDTH:0]  LAST   = (AWIDTH+1)'(DEPTH - 1);

  if (!param_ok(DWIDTH, AWIDTH, DEPTH)) begin : g_bad_params
    $error("coreabc_ram_param: illegal DWIDTH/AWIDTH/DEPTH combination");
  end

  state_e            state;
  logic              busy;
  logic [AWIDTH:0]   clr_cnt;
  logic              wa_ok, ra_ok, wr_acc, rd_acc;
  logic              arr_we;
  logic [AWIDTH-1:0] arr_waddr;
  logic [DWIDTH-1:0] arr_wd, arr_rd;
  logic [NBE-1:0]    arr_wbe;
  logic [STAGES:0]   vld_pipe;

  // A full-size array has no unreachable addresses.
  if (DEPTH == (1 << AWIDTH)) begin : g_full
    assign wa_ok = 1'b1;
    assign ra_ok = 1'b1;
  end else begin : g_part
    assign wa_ok = ({1'b0, bus.WADDR} < LAST + 1'b1);
    assign ra_ok = ({1'b0, bus.RADDR} < LAST + 1'b1);
  end

  always_ff @(posedge RWCLK or negedge RESETN) begin
    if (!RESETN) begin
      state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      busy    <= (CLEAR_ON_RESET != 0);
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == LAST) begin
        state <= ST_READY;
        busy  <= 1'b0;
      end
    end
  end

  assign wr_acc    = !busy && bus.WEN && wa_ok;
  assign rd_acc    = !busy && bus.REN;
  // The clearer owns the write port for its whole run.
  assign arr_we    = busy || wr_acc;
  assign arr_waddr = busy ? clr_cnt[AWIDTH-1:0] : bus.WADDR;
  assign arr_wd    = busy ? '0 : bus.WD;
  assign arr_wbe   = busy ? '1 : bus.WBE;

  coreabc_ram_param_array #(
    .DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .DEPTH(DEPTH), .RDW_MODE(RDW_MODE)
  ) u_array (
    .clk  (RWCLK),
    .rst_n(RESETN),
    .we   (arr_we),
    .waddr(arr_waddr),
    .wbe  (arr_wbe),
    .wd   (arr_wd),
    .re   (rd_acc),
    .rclr (!ra_ok),
    .raddr(bus.RADDR),
    .rd   (arr_rd)
  );

  always_ff @(posedge RWCLK or negedge RESETN) begin
    if (!RESETN) vld_pipe <= '0;
    else begin
      vld_pipe[0] <= rd_acc;
      for (int i = 1; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DWIDTH-1:0] rd_q;
    always_ff @(posedge RWCLK or negedge RESETN) begin
      if (!RESETN)          rd_q <= '0;
      else if (vld_pipe[0]) rd_q <= arr_rd;
    end
    assign bus.RD = rd_q;
  end else begin : g_noreg
    assign bus.RD = arr_rd;
  end

  assign bus.RVALID = vld_pipe[STAGES];
  assign bus.BUSY   = busy;
endmodule

// File: tb/tb_coreabc_ram_param.sv
// Directed bench: four RAM variants (read-first, write-first, output-registered,
// DEPTH=200) driven by one shared stimulus and checked against fixed values.
module tb_coreabc_ram_param;
  logic        clk;
  logic        rst_n;
  logic        wen, ren;
  logic [7:0]  waddr, raddr;
  logic [15:0] wd;
  logic [1:0]  wbe;

  logic [15:0] rd     [4];
  logic        rvalid [4];
  logic        busy   [4];

  int n_chk = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: DEPTH 256 read-first, 1: write-first, 2: output register, 3: DEPTH 200
  for (genvar g = 0; g < 4; g++) begin : g_dut
    coreabc_ram_param_if #(.DWIDTH(16), .AWIDTH(8)) bus ();
    assign bus.WEN   = wen;
    assign bus.REN   = ren;
    assign bus.WADDR = waddr;
    assign bus.RADDR = raddr;
    assign bus.WD    = wd;
    assign bus.WBE   = wbe;
    assign rd[g]     = bus.RD;
    assign rvalid[g] = bus.RVALID;
    assign busy[g]   = bus.BUSY;

    coreabc_ram_param #(
      .DWIDTH(16), .AWIDTH(8),
      .DEPTH((g == 3) ? 200 : 256),
      .RDW_MODE((g == 1) ? 1 : 0),
      .OUT_REG((g == 2) ? 1 : 0),
      .CLEAR_ON_RESET(1)
    ) dut (
      .RWCLK (clk),
      .RESETN(rst_n),
      .bus   (bus)
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] be);
    wen = 1'b1; waddr = a; wd = d; wbe = be;
    tick();
    wen = 1'b0;
  endtask

  task automatic rd_op(input logic [7:0] a);
    ren = 1'b1; raddr = a;
    tick();
    ren = 1'b0;
  endtask

  // Runs edges until DUT 0 leaves BUSY (or stop_at edges), pulsing a write
  // and read of paddr at edge pulse_cyc; records when DUTs 0 and 3 finished.
  task automatic clear_run(input int pulse_cyc, input logic [7:0] paddr, input int stop_at,
                           output int c0, output int c3, output int rv);
    int cnt;
    c0 = 0; c3 = 0; rv = 0; cnt = 0;
    while (cnt < 600) begin
      if (cnt == pulse_cyc) begin
        wen = 1'b1; ren = 1'b1; waddr = paddr; raddr = paddr; wd = 16'hFFFF; wbe = 2'b11;
      end else begin
        wen = 1'b0; ren = 1'b0;
      end
      tick();
      cnt++;
      for (int g = 0; g < 4; g++) if (rvalid[g]) rv++;
      if (!busy[3] && c3 == 0) c3 = cnt;
      if (!busy[0] && c0 == 0) c0 = cnt;
      if (!busy[0] || cnt == stop_at) break;
    end
    wen = 1'b0; ren = 1'b0;
  endtask

  initial begin
    int c0, c3, rv;
    rst_n = 1'b0; wen = 1'b0; ren = 1'b0;
    waddr = '0; raddr = '0; wd = '0; wbe = '0;
    repeat (2) tick();

    chk("rst_busy0", 32'(busy[0]), 1);
    chk("rst_busy3", 32'(busy[3]), 1);
    chk("rst_rvalid", 32'(rvalid[0]), 0);
    chk("rst_rd", 32'(rd[2]), 0);

    // Clear after first reset release, with an access attempted while busy
    rst_n = 1'b1;
    clear_run(10, 8'h05, -1, c0, c3, rv);
    chk("clr_len_256", 32'(c0), 256);
    chk("clr_len_200", 32'(c3), 200);
    chk("clr_no_rvalid", 32'(rv), 0);
    chk("clr_busy2_done", 32'(busy[2]), 0);

    rd_op(8'h00); chk("rd00_v", 32'(rvalid[0]), 1); chk("rd00_d", 32'(rd[0]), 0);
    rd_op(8'h7F); chk("rd7f_v", 32'(rvalid[0]), 1); chk("rd7f_d", 32'(rd[0]), 0);
    rd_op(8'hFF); chk("rdff_v", 32'(rvalid[0]), 1); chk("rdff_d", 32'(rd[0]), 0);
    rd_op(8'h05); chk("busy_wr_ignored", 32'(rd[0]), 0);
    tick();       chk("idle_rvalid", 32'(rvalid[0]), 0);

    // Byte-lane writes
    wr(8'h10, 16'hA5A5, 2'b11);
    wr(8'h10, 16'h3C00, 2'b10);
    rd_op(8'h10); chk("be_merge", 32'(rd[0]), 32'h3CA5);
    wr(8'h10, 16'hFFFF, 2'b00);
    rd_op(8'h10); chk("be_none", 32'(rd[0]), 32'h3CA5);
    tick();
    chk("rd_hold", 32'(rd[0]), 32'h3CA5);
    chk("hold_rvalid", 32'(rvalid[0]), 0);

    // Read-during-write on the same address
    wr(8'h20, 16'h1111, 2'b11);
    wen = 1'b1; waddr = 8'h20; wd = 16'h2222; wbe = 2'b11;
    ren = 1'b1; raddr = 8'h20;
    tick();
    wen = 1'b0; ren = 1'b0;
    chk("rdw_old", 32'(rd[0]), 32'h1111);
    chk("rdw_new", 32'(rd[1]), 32'h2222);
    rd_op(8'h20);
    chk("rdw_after0", 32'(rd[0]), 32'h2222);
    chk("rdw_after1", 32'(rd[1]), 32'h2222);

    // Back-to-back reads, latency 1 and latency 2
    wr(8'h01, 16'h0101, 2'b11);
    wr(8'h02, 16'h0202, 2'b11);
    wr(8'h03, 16'h0303, 2'b11);
    ren = 1'b1; raddr = 8'h01; tick();
    chk("oreg_v0", 32'(rvalid[2]), 0);
    chk("b2b_d1", 32'(rd[0]), 32'h0101);
    raddr = 8'h02; tick();
    chk("oreg_v1", 32'(rvalid[2]), 1); chk("oreg_d1", 32'(rd[2]), 32'h0101);
    chk("b2b_d2", 32'(rd[0]), 32'h0202);
    raddr = 8'h03; tick();
    ren = 1'b0;
    chk("oreg_v2", 32'(rvalid[2]), 1); chk("oreg_d2", 32'(rd[2]), 32'h0202);
    chk("b2b_d3", 32'(rd[0]), 32'h0303);
    tick();
    chk("oreg_v3", 32'(rvalid[2]), 1); chk("oreg_d3", 32'(rd[2]), 32'h0303);
    tick();
    chk("oreg_v4", 32'(rvalid[2]), 0); chk("oreg_hold", 32'(rd[2]), 32'h0303);

    // Out-of-range access on the 200-word variant
    wr(8'hC8, 16'hFFFF, 2'b11);
    rd_op(8'hC8);
    chk("oor_v", 32'(rvalid[3]), 1);
    chk("oor_d", 32'(rd[3]), 0);
    chk("inrange_c8", 32'(rd[0]), 32'hFFFF);
    rd_op(8'h00);
    chk("oor_w0", 32'(rd[3]), 0);

    // Reset during the clear sequence restarts it from word 0
    rd_op(8'h10);
    chk("pre_rst_rd", 32'(rd[0]), 32'h3CA5);
    rst_n = 1'b0; tick();
    chk("rst2_rd", 32'(rd[0]), 0);
    chk("rst2_busy", 32'(busy[0]), 1);
    rst_n = 1'b1;
    clear_run(-1, 8'h00, 100, c0, c3, rv);
    chk("mid_busy", 32'(busy[0]), 1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    clear_run(50, 8'h10, -1, c0, c3, rv);
    chk("restart_len", 32'(c0), 256);
    chk("restart_no_rvalid", 32'(rv), 0);
    rd_op(8'h10);
    chk("restart_w10", 32'(rd[0]), 0);
    chk("restart_w10_v", 32'(rvalid[1]), 1);
    rd_op(8'hC8);
    chk("restart_wc8", 32'(rd[0]), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, limit 100000 ns");
    $fatal(1);
  end
endmodule
